// File: rtl/pulse_width_meter_pkg.sv
// Shared types and defaults for the pulse width meter and its input conditioning.
package pulse_width_meter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } pwm_state_t;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;

    function automatic int max_count(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronises an asynchronous level into clk and flags its rising/falling edges.
module sync_edge_detect
    import pulse_width_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            s_d    <= sync_q[SYNC_STAGES-1];
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures the synchronised high time of sig_in in clk cycles, saturating at MAX.
//   state     | meaning
//   IDLE      | waiting for arm; meas/overflow hold last result
//   WAIT_RISE | armed, waiting for a fresh rising edge
//   MEASURE   | counting high cycles until the falling edge
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MAX         = max_count(WIDTH),
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             arm,
    input  logic             cancel,
    output logic [WIDTH-1:0] meas,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_CNT = MAX[WIDTH-1:0];

    pwm_state_t       state;
    logic [WIDTH-1:0] cnt;
    logic             s;
    logic             rise;
    logic             fall;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .sig_in(sig_in),
        .s     (s),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            meas     <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (arm && !cancel) begin
                        state <= WAIT_RISE;
                        busy  <= 1'b1;
                    end
                end
                WAIT_RISE: begin
                    // a level already high at arm time never produces rise
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (rise) begin
                        state <= MEASURE;
                        cnt   <= WIDTH'(1);
                    end
                end
                MEASURE: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fall) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        meas     <= cnt;
                        overflow <= (cnt == MAX_CNT);
                        valid    <= 1'b1;
                    end else if (s && (cnt != MAX_CNT)) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
